fetch_decode: RTL and testbench

Fetch-address generator and IF/ID pipeline register for the five-stage RISC-V core, directly upstream of the forwarding control unit. Drives a one-cycle-latency instruction memory, holds the decode-stage instruction, and presents both the decode-stage register fields (addrD/addrA/addrB/OPC) and the fetch-side lookahead fields (addrA1/addrB1/OPC1) that forwarding/hazard logic consumes. Handles load-use stalls with a one-entry skid register and branch/jump redirects with a fill cycle.

---
 rtl/fetch_decode_pkg.sv | 37 +++
 rtl/fetch_decode_field_dec.sv | 20 ++
 rtl/fetch_decode.sv | 140 ++++++++++++++
 tb/tb_fetch_decode.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode slice: opcodes, bubble word, FSM encoding
// and instruction field positions.
package fetch_decode_pkg;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  // Opcode values shared with the forwarding unit
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] ECALL  = 7'b1110011;

  localparam int REG_W   = 5;
  localparam int OPC_W   = 7;
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fd_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_decode_field_dec.sv
// Combinational split of a 32-bit RISC-V instruction into rd/rs1/rs2/opcode.
module inst_field_dec
  import fetch_decode_pkg::*;
(
  input  logic [31:0]      inst,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [OPC_W-1:0] opcode
);

  assign rd     = inst[RD_LSB  +: REG_W];
  assign rs1    = inst[RS1_LSB +: REG_W];
  assign rs2    = inst[RS2_LSB +: REG_W];
  assign opcode = inst[OPC_LSB +: OPC_W];

  logic unused_fields;
  assign unused_fields = ^{inst[31:25], inst[14:12]};

endmodule

// File: rtl/fetch_decode.sv
// Fetch-address generator and IF/ID register with one-entry skid for stalls and a
// fill cycle after redirects; exposes decode and lookahead register fields.
module fetch_decode
  import fetch_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_D,
  output logic [31:0] inst_D,
  output logic        valid_D,
  output logic [4:0]  addrD,
  output logic [4:0]  addrA,
  output logic [4:0]  addrB,
  output logic [6:0]  OPC,
  output logic [4:0]  addrA1,
  output logic [4:0]  addrB1,
  output logic [6:0]  OPC1
);

  fd_state_t   state, state_nx;
  logic [31:0] fa, fa_nx;
  logic [31:0] ra, ra_nx;
  logic [31:0] skid, skid_nx;
  logic [31:0] skid_pc, skid_pc_nx;
  logic [31:0] pc_nx, inst_nx;
  logic        valid_nx;
  logic [31:0] look_inst;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      fa      <= RESET_PC;
      ra      <= RESET_PC;
      // NOTE: the skid is a single register, not an array, so it is reset like any other flop.
      skid    <= NOP_INST;
      skid_pc <= RESET_PC;
      pc_D    <= RESET_PC;
      inst_D  <= NOP_INST;
      valid_D <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state   <= state_nx;
      fa      <= fa_nx;
      ra      <= ra_nx;
      skid    <= skid_nx;
      skid_pc <= skid_pc_nx;
      pc_D    <= pc_nx;
      inst_D  <= inst_nx;
      valid_D <= valid_nx;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first keep this block free of latches.
    state_nx   = state;
    fa_nx      = fa;
    ra_nx      = ra;
    skid_nx    = skid;
    skid_pc_nx = skid_pc;
    pc_nx      = pc_D;
    inst_nx    = inst_D;
    valid_nx   = valid_D;
    look_inst  = NOP_INST;

    if (redirect) begin
      // Data returning for the old fetch address is dropped by the fill cycle.
      fa_nx    = word_align(redirect_pc);
      inst_nx  = NOP_INST;
      valid_nx = 1'b0;
      skid_nx  = NOP_INST;
      state_nx = FILL;
    end else begin
      case (state)
        FILL: if (!stall) begin
          inst_nx  = NOP_INST;
          valid_nx = 1'b0;
          ra_nx    = fa;
          fa_nx    = fa + 32'd4;
          state_nx = RUN;
        end
        RUN: if (!stall) begin
          inst_nx  = imem_rdata;
          pc_nx    = ra;
          valid_nx = 1'b1;
          ra_nx    = fa;
          fa_nx    = fa + 32'd4;
        end else begin
          skid_nx    = imem_rdata;
          skid_pc_nx = ra;
          state_nx   = HOLD;
        end
        HOLD: if (!stall) begin
          inst_nx  = skid;
          pc_nx    = skid_pc;
          valid_nx = 1'b1;
          ra_nx    = fa;
          fa_nx    = fa + 32'd4;
          state_nx = RUN;
        end
        default: state_nx = FILL;
      endcase
    end

    case (state)
      RUN:     look_inst = imem_rdata;
      HOLD:    look_inst = skid;
      default: look_inst = NOP_INST;
    endcase
  end

  assign imem_addr = fa;

  logic unused_rd1;
  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = redirect_pc[1:0];

  inst_field_dec u_dec_d (
    .inst   (inst_D),
    .rd     (addrD),
    .rs1    (addrA),
    .rs2    (addrB),
    .opcode (OPC)
  );

  logic [4:0] look_rd;
  inst_field_dec u_dec_look (
    .inst   (look_inst),
    .rd     (look_rd),
    .rs1    (addrA1),
    .rs2    (addrB1),
    .opcode (OPC1)
  );
  assign unused_rd1 = ^look_rd;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: stimulus queues expected decode PCs, a negedge
// monitor pops and compares whenever valid_D is high.
module tb_fetch_decode;
  import fetch_decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_D, inst_D;
  logic        valid_D;
  logic [4:0]  addrD, addrA, addrB, addrA1, addrB1;
  logic [6:0]  OPC, OPC1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  // Instruction memory: one-cycle latency, each word equals its address.
  always_ff @(posedge clock) imem_rdata <= imem_addr;

  fetch_decode dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_D(pc_D), .inst_D(inst_D), .valid_D(valid_D),
    .addrD(addrD), .addrA(addrA), .addrB(addrB), .OPC(OPC),
    .addrA1(addrA1), .addrB1(addrB1), .OPC1(OPC1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_range(input logic [31:0] first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  // Monitor: every valid decode slot must match the next queued PC (word = address).
  always @(negedge clock) begin
    if (!reset && valid_D) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got pc_D 0x%08h expected none", pc_D);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pc_D", pc_D, e);
        check("inst_D", inst_D, e);
        check("addrD", {27'd0, addrD}, {27'd0, e[11:7]});
        check("addrA", {27'd0, addrA}, {27'd0, e[19:15]});
        check("addrB", {27'd0, addrB}, {27'd0, e[24:20]});
        check("OPC", {25'd0, OPC}, {25'd0, e[6:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;

    // Reset state
    tick();
    check("rst_imem_addr", imem_addr, 32'h0100_0000);
    check("rst_inst_D", inst_D, 32'h0000_0013);
    check("rst_valid_D", {31'd0, valid_D}, 32'd0);
    check("rst_pc_D", pc_D, 32'h0100_0000);
    check("rst_OPC", {25'd0, OPC}, 32'h13);
    check("rst_addrD", {27'd0, addrD}, 32'd0);
    check("rst_OPC1", {25'd0, OPC1}, 32'h13);

    // Straight line: 0x01000000 .. 0x0100001C
    push_range(32'h0100_0000, 8);
    reset = 1'b0;
    tick();
    check("fill_imem_addr", imem_addr, 32'h0100_0004);
    check("fill_valid_D", {31'd0, valid_D}, 32'd0);
    check("fill_inst_D", inst_D, 32'h0000_0013);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("run_valid_D", {31'd0, valid_D}, 32'd1);
      w = 32'h0100_0004 + 32'(4 * i);
      check("run_OPC1", {25'd0, OPC1}, {25'd0, w[6:0]});
      check("run_addrB1", {27'd0, addrB1}, {27'd0, w[24:20]});
    end

    // Redirect back to base, 1-cycle stall at 08, 3-cycle stall at 14
    exp_q.push_back(32'h0100_0000);
    exp_q.push_back(32'h0100_0004);
    exp_q.push_back(32'h0100_0008);
    exp_q.push_back(32'h0100_0008);
    exp_q.push_back(32'h0100_000C);
    exp_q.push_back(32'h0100_0010);
    repeat (4) exp_q.push_back(32'h0100_0014);
    exp_q.push_back(32'h0100_0018);
    exp_q.push_back(32'h0100_001C);
    redirect = 1'b1;
    redirect_pc = 32'h0100_0003;
    tick();
    redirect = 1'b0;
    check("redir0_imem_addr", imem_addr, 32'h0100_0000);
    tick();
    repeat (3) tick();
    stall = 1'b1;
    tick();
    check("hold_OPC1", {25'd0, OPC1}, 32'h0C);
    check("hold_addrB1", {27'd0, addrB1}, 32'h10);
    check("hold_addrA1", {27'd0, addrA1}, 32'h0);
    stall = 1'b0;
    repeat (3) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    repeat (2) tick();

    // Redirect to 0x01000103 while RUN
    exp_q.push_back(32'h0100_0100);
    exp_q.push_back(32'h0100_0104);
    redirect = 1'b1;
    redirect_pc = 32'h0100_0103;
    tick();
    redirect = 1'b0;
    check("redir_imem_addr", imem_addr, 32'h0100_0100);
    check("redir_valid_D0", {31'd0, valid_D}, 32'd0);
    check("redir_inst_D", inst_D, 32'h0000_0013);
    tick();
    check("redir_valid_D1", {31'd0, valid_D}, 32'd0);
    check("redir_imem_addr1", imem_addr, 32'h0100_0104);
    repeat (2) tick();

    // Stall into HOLD, then redirect + stall together
    exp_q.push_back(32'h0100_0104);
    push_range(32'h0100_0100, 3);
    stall = 1'b1;
    tick();
    check("hold2_OPC1", {25'd0, OPC1}, 32'h08);
    redirect = 1'b1;
    redirect_pc = 32'h0100_0103;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    check("redir_hold_imem_addr", imem_addr, 32'h0100_0100);
    check("redir_hold_valid0", {31'd0, valid_D}, 32'd0);
    check("redir_hold_OPC1", {25'd0, OPC1}, 32'h13);
    tick();
    check("redir_hold_valid1", {31'd0, valid_D}, 32'd0);
    repeat (3) tick();

    // Asynchronous reset asserted between edges while in HOLD
    exp_q.push_back(32'h0100_0108);
    stall = 1'b1;
    tick();
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("areset_imem_addr", imem_addr, 32'h0100_0000);
    check("areset_valid_D", {31'd0, valid_D}, 32'd0);
    check("areset_inst_D", inst_D, 32'h0000_0013);
    check("areset_pc_D", pc_D, 32'h0100_0000);
    check("areset_OPC1", {25'd0, OPC1}, 32'h13);
    stall = 1'b0;
    tick();
    push_range(32'h0100_0000, 2);
    reset = 1'b0;
    tick();
    check("rel_valid_D", {31'd0, valid_D}, 32'd0);
    check("rel_imem_addr", imem_addr, 32'h0100_0004);
    repeat (2) tick();
    @(negedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
